// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_DM = 1'b1
    } owner_e;

    function automatic arb_state_e busy_state(input owner_e owner);
        return (owner == OWNER_DM) ? DM_BUSY : IF_BUSY;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Access watchdog: cleared on grant, counts stalled busy cycles.
module mem_arb_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] r_cnt;

    // Expired marks the last permitted stalled cycle: a further stall aborts.
    assign o_expired = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between fetch and data stages.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_err
);

    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    arb_state_e        r_state;
    arb_state_e        w_state_nx;
    logic [SW-1:0]     r_starve;
    logic              r_if_valid;
    logic              r_dm_valid;
    logic              r_bus_err;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    logic w_if_elig;
    logic w_dm_elig;
    logic w_grant_if;
    logic w_grant_dm;
    logic w_done;
    logic w_abort;
    logic w_busy;
    logic w_expired;

    // A requester whose valid is high has just completed and must not be re-granted.
    assign w_if_elig = if_req & ~r_if_valid;
    assign w_dm_elig = dm_req & ~r_dm_valid;
    assign w_busy    = (r_state != IDLE);

    mem_arb_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .i_clr    (w_grant_if | w_grant_dm),
        .i_en     (w_busy & ~mem_ready),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_grant_if = 1'b0;
        w_grant_dm = 1'b0;
        w_done     = 1'b0;
        w_abort    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_dm_elig && !(w_if_elig && r_starve == SW'(STARVE_MAX))) begin
                    w_grant_dm = 1'b1;
                    w_state_nx = busy_state(OWNER_DM);
                end else if (w_if_elig) begin
                    w_grant_if = 1'b1;
                    w_state_nx = busy_state(OWNER_IF);
                end
            end
            IF_BUSY, DM_BUSY: begin
                w_done  = mem_ready;
                w_abort = ~mem_ready & w_expired;
                if (w_done || w_abort) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve    <= '0;
            r_if_valid  <= 1'b0;
            r_dm_valid  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            r_bus_err  <= 1'b0;
            if (w_grant_if) begin
                r_mem_addr <= if_addr;
                r_mem_we   <= 1'b0;
                r_starve   <= '0;
            end
            if (w_grant_dm) begin
                r_mem_addr  <= dm_addr;
                r_mem_we    <= dm_we;
                r_mem_wdata <= dm_wdata;
                if (w_if_elig && r_starve != SW'(STARVE_MAX)) begin
                    r_starve <= r_starve + 1'b1;
                end
            end
            if (w_done || w_abort) begin
                r_bus_err <= w_abort;
                r_mem_we  <= 1'b0;
                if (r_state == IF_BUSY) begin
                    r_if_valid <= 1'b1;
                    r_if_rdata <= w_done ? mem_rdata : '0;
                end else begin
                    r_dm_valid <= 1'b1;
                    if (!r_mem_we) begin
                        r_dm_rdata <= w_done ? mem_rdata : '0;
                    end
                end
            end
        end
    end

    assign mem_req   = w_busy;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_valid  = r_if_valid;
    assign dm_valid  = r_dm_valid;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign bus_err   = r_bus_err;
    assign if_stall  = if_req & ~r_if_valid;
    assign dm_stall  = dm_req & ~r_dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        bus_err;

    int total;
    int bad;

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_MAX(4),
        .TIMEOUT   (255)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .if_stall (if_stall),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_valid (dm_valid),
        .dm_stall (dm_stall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .bus_err  (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
        tick(); tick();
        rst = 1'b1;
        dm_req = 1; dm_we = 0; dm_addr = 32'h40;
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
            bad++; $display("FAIL rst_grant mem_req=%0b addr=%h exp 1/00000040", mem_req, mem_addr);
        end
        tick(); tick();
        #2 rst = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0) begin
            bad++; $display("FAIL rst_async_req got=%0b exp=0", mem_req);
        end
        dm_req = 0;
        tick();
        total++; if ({mem_req, mem_we, if_valid, dm_valid, bus_err, if_stall, dm_stall} !== 7'b0 ||
                     mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || dm_rdata !== '0) begin
            bad++; $display("FAIL rst_outputs req=%0b we=%0b iv=%0b dv=%0b err=%0b addr=%h exp all 0",
                            mem_req, mem_we, if_valid, dm_valid, bus_err, mem_addr);
        end
        rst = 1'b1;
        tick();
        total++; if (mem_req !== 1'b0 || dm_valid !== 1'b0) begin
            bad++; $display("FAIL rst_release req=%0b dv=%0b exp 0/0", mem_req, dm_valid);
        end
    endtask

    task automatic test_single_fetch();
        mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        total++; if (mem_req !== 1'b0 || if_valid !== 1'b0 || dm_valid !== 1'b0) begin
            bad++; $display("FAIL idle_ready_ignored req=%0b iv=%0b dv=%0b exp 0", mem_req, if_valid, dm_valid);
        end
        if_req = 1; if_addr = 32'h10; mem_rdata = 32'h0050_0093;
        #1;
        total++; if (if_stall !== 1'b1) begin
            bad++; $display("FAIL sf_stall_pre got=%0b exp=1", if_stall);
        end
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0 || if_stall !== 1'b1) begin
            bad++; $display("FAIL sf_grant req=%0b addr=%h we=%0b stall=%0b exp 1/00000010/0/1",
                            mem_req, mem_addr, mem_we, if_stall);
        end
        tick();
        total++; if (if_valid !== 1'b1 || if_rdata !== 32'h0050_0093 || if_stall !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL sf_done iv=%0b rdata=%h stall=%0b req=%0b exp 1/00500093/0/0",
                            if_valid, if_rdata, if_stall, mem_req);
        end
        if_req = 0; mem_ready = 0;
        tick();
        total++; if (if_valid !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL sf_pulse_end iv=%0b req=%0b exp 0/0", if_valid, mem_req);
        end
    endtask

    task automatic test_contention();
        if_req = 1; if_addr = 32'h20;
        dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hCAFE;
        mem_ready = 0;
        tick();
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'hCAFE) begin
            bad++; $display("FAIL ct_store_first req=%0b we=%0b addr=%h wdata=%h exp 1/1/00000200/0000cafe",
                            mem_req, mem_we, mem_addr, mem_wdata);
        end
        tick();
        total++; if (mem_req !== 1'b1 || dm_valid !== 1'b0) begin
            bad++; $display("FAIL ct_wait req=%0b dv=%0b exp 1/0", mem_req, dm_valid);
        end
        mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        total++; if (dm_valid !== 1'b1 || dm_rdata !== 32'h0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
                     dm_stall !== 1'b0 || if_stall !== 1'b1) begin
            bad++; $display("FAIL ct_store_done dv=%0b rdata=%h req=%0b we=%0b dstall=%0b istall=%0b exp 1/0/0/0/0/1",
                            dm_valid, dm_rdata, mem_req, mem_we, dm_stall, if_stall);
        end
        dm_we = 0; dm_addr = 32'h204; mem_ready = 0;
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h20 || mem_we !== 1'b0) begin
            bad++; $display("FAIL ct_no_regrant req=%0b addr=%h we=%0b exp 1/00000020/0", mem_req, mem_addr, mem_we);
        end
        tick();
        mem_ready = 1; mem_rdata = 32'h1111_2222;
        tick();
        total++; if (if_valid !== 1'b1 || if_rdata !== 32'h1111_2222) begin
            bad++; $display("FAIL ct_fetch_done iv=%0b rdata=%h exp 1/11112222", if_valid, if_rdata);
        end
        mem_rdata = 32'h5555;
        tick();
        if_req = 0;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h204 || mem_we !== 1'b0) begin
            bad++; $display("FAIL ct_load_grant req=%0b addr=%h we=%0b exp 1/00000204/0", mem_req, mem_addr, mem_we);
        end
        tick();
        total++; if (dm_valid !== 1'b1 || dm_rdata !== 32'h5555) begin
            bad++; $display("FAIL ct_load_done dv=%0b rdata=%h exp 1/00005555", dm_valid, dm_rdata);
        end
        dm_req = 0; mem_ready = 0;
        tick();
    endtask

    task automatic test_starvation();
        mem_ready = 1; dm_we = 0; if_addr = 32'h30;
        for (int i = 0; i < 4; i++) begin
            if_req = 1; dm_req = 1; dm_addr = 32'h400 + 32'(i * 4); mem_rdata = 32'hA0 + 32'(i);
            tick();
            total++; if (mem_req !== 1'b1 || mem_addr !== 32'h400 + 32'(i * 4)) begin
                bad++; $display("FAIL sv_dm_grant%0d req=%0b addr=%h exp 1/%h", i, mem_req, mem_addr, 32'h400 + 32'(i * 4));
            end
            tick();
            total++; if (dm_valid !== 1'b1 || dm_rdata !== 32'hA0 + 32'(i)) begin
                bad++; $display("FAIL sv_dm_done%0d dv=%0b rdata=%h exp 1/%h", i, dm_valid, dm_rdata, 32'hA0 + 32'(i));
            end
            if_req = 0;
            tick();
        end
        if_req = 1; dm_addr = 32'h410; mem_rdata = 32'h600;
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h30 || mem_we !== 1'b0) begin
            bad++; $display("FAIL sv_fetch_forced req=%0b addr=%h we=%0b exp 1/00000030/0", mem_req, mem_addr, mem_we);
        end
        tick();
        total++; if (if_valid !== 1'b1 || if_rdata !== 32'h600) begin
            bad++; $display("FAIL sv_fetch_done iv=%0b rdata=%h exp 1/00000600", if_valid, if_rdata);
        end
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h410) begin
            bad++; $display("FAIL sv_dm_resume req=%0b addr=%h exp 1/00000410", mem_req, mem_addr);
        end
        tick();
        if_req = 0;
        tick();
        if_req = 1; dm_addr = 32'h414;
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h414) begin
            bad++; $display("FAIL sv_cnt_cleared req=%0b addr=%h exp 1/00000414", mem_req, mem_addr);
        end
        tick();
        if_req = 0; dm_req = 0; mem_ready = 0;
        tick();
    endtask

    task automatic test_timeout(input logic we, input logic ready_at_end, input logic [31:0] addr,
                                input logic [31:0] exp_rdata, input string tag);
        dm_req = 1; dm_we = we; dm_addr = addr; dm_wdata = 32'h77; mem_ready = 0; mem_rdata = 32'h1234;
        tick();
        for (int c = 0; c < 254; c++) begin
            tick();
            total++; if (mem_req !== 1'b1 || bus_err !== 1'b0 || dm_valid !== 1'b0) begin
                bad++; $display("FAIL %s_busy%0d req=%0b err=%0b dv=%0b exp 1/0/0", tag, c, mem_req, bus_err, dm_valid);
            end
        end
        mem_ready = ready_at_end;
        tick();
        dm_req = 0; mem_ready = 0;
        total++; if (bus_err !== ~ready_at_end || dm_valid !== 1'b1 || dm_rdata !== exp_rdata || mem_req !== 1'b0) begin
            bad++; $display("FAIL %s_end err=%0b dv=%0b rdata=%h req=%0b exp %0b/1/%h/0",
                            tag, bus_err, dm_valid, dm_rdata, mem_req, ~ready_at_end, exp_rdata);
        end
        tick();
        total++; if (bus_err !== 1'b0 || dm_valid !== 1'b0) begin
            bad++; $display("FAIL %s_pulse_end err=%0b dv=%0b exp 0/0", tag, bus_err, dm_valid);
        end
    endtask

    task automatic test_reset_clears();
        #2 rst = 1'b0;
        #1;
        total++; if (dm_rdata !== '0 || if_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
            bad++; $display("FAIL rst_clear dr=%h ir=%h addr=%h wd=%h exp 0", dm_rdata, if_rdata, mem_addr, mem_wdata);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_timeout(1'b0, 1'b0, 32'h300, 32'h0, "to_load");
        test_timeout(1'b0, 1'b1, 32'h304, 32'h1234, "to_edge");
        test_timeout(1'b1, 1'b0, 32'h308, 32'h1234, "to_store");
        test_reset_clears();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
